// File: rtl/kuz_pkg.sv
// Shared constants, types and the GF(2^8) multiply/accumulate slice for the Kuznechik linear layer.
package kuz_pkg;

    localparam logic [7:0] KUZ_POLY    = 8'hC3;
    localparam int         KUZ_BLOCK_W = 128;

    // Coefficients of l, first entry multiplies a15, last multiplies a0.
    localparam logic [7:0] L_COEFF [0:15] = '{
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1,   8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } kuz_state_e;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] c;
    } mult_part_t;

    // One shift-and-add step: accumulate a when b is set, then a = a*x mod poly.
    function automatic mult_part_t mult_part(input mult_part_t s, input logic b);
        mult_part_t r;
        r.c = b ? (s.c ^ s.a) : s.c;
        r.a = {s.a[6:0], 1'b0} ^ (s.a[7] ? KUZ_POLY : 8'h00);
        return r;
    endfunction

endpackage

// File: rtl/kuz_l_func.sv
// Combinational l(): sixteen constant GF(2^8) multiplies of the block bytes, XOR-reduced to one byte.
module kuz_l_func
    import kuz_pkg::*;
(
    input  logic [KUZ_BLOCK_W-1:0] blk_i,
    output logic [7:0]             l_o
);

    logic [7:0] prod [16];

    for (genvar i = 0; i < 16; i++) begin : g_coeff
        mult_part_t chain [8];

        assign chain[0] = '{a: blk_i[KUZ_BLOCK_W-1-8*i -: 8], c: 8'h00};
        for (genvar j = 0; j < 7; j++) begin : g_bit
            assign chain[j+1] = mult_part(chain[j], L_COEFF[i][j]);
        end
        // The eighth slice only accumulates; its doubled a would never be read.
        assign prod[i] = chain[7].c ^ (L_COEFF[i][7] ? chain[7].a : 8'h00);
    end

    always_comb begin
        // NOTE: default assignment first so the loop below can never infer a latch.
        l_o = 8'h00;
        for (int i = 0; i < 16; i++) begin
            l_o ^= prod[i];
        end
    end

endmodule

// File: rtl/kuz_l_transform.sv
// Sequential Kuznechik L / L^-1 layer: one R (or R^-1) step per clock for ROUNDS clocks, valid/ready both sides.
module kuz_l_transform
    import kuz_pkg::*;
#(
    parameter int ROUNDS  = 16,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data
);

    localparam int             CNT_W = $clog2(ROUNDS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

    if (BLOCK_W != KUZ_BLOCK_W) begin : g_bad_width
        $error("kuz_l_transform: BLOCK_W must be 128");
    end
    if (ROUNDS < 1) begin : g_bad_rounds
        $error("kuz_l_transform: ROUNDS must be at least 1");
    end

    kuz_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BLOCK_W-1:0] work_q;
    logic               inv_q;
    logic               out_valid_q;
    logic [BLOCK_W-1:0] out_data_q;

    logic [BLOCK_W-1:0] l_in;
    logic [BLOCK_W-1:0] step_d;
    logic [7:0]         l_byte;
    logic               accept;

    // Inverse step evaluates l on the block rotated left by one byte and feeds the result in at a0.
    always_comb begin
        l_in   = inv_q ? {work_q[BLOCK_W-9:0], work_q[BLOCK_W-1 -: 8]} : work_q;
        step_d = inv_q ? {work_q[BLOCK_W-9:0], l_byte} : {l_byte, work_q[BLOCK_W-1:8]};
    end

    kuz_l_func u_l_func (
        .blk_i (l_in),
        .l_o   (l_byte)
    );

    // in_ready is gated by rst directly so it reads low in every reset cycle.
    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        work_q  <= in_data;
                        inv_q   <= in_inv;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    work_q <= step_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= step_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_kuz_l_transform.sv
// Scoreboard bench for kuz_l_transform: single-step (ROUNDS=1) and full-L (ROUNDS=16) instances side by side.
module tb_kuz_l_transform;

    typedef struct {
        bit           chk;
        logic [127:0] exp;
        int           lat;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         v1, rdy1, inv1, ov1, ord1;
    logic [127:0] d1, od1;
    logic         v16, rdy16, inv16, ov16, ord16;
    logic [127:0] d16, od16;

    kuz_l_transform #(.ROUNDS(1), .BLOCK_W(128)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .in_ready  (rdy1),
        .in_data   (d1),
        .in_inv    (inv1),
        .out_valid (ov1),
        .out_ready (ord1),
        .out_data  (od1)
    );

    kuz_l_transform #(.ROUNDS(16), .BLOCK_W(128)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v16),
        .in_ready  (rdy16),
        .in_data   (d16),
        .in_inv    (inv16),
        .out_valid (ov16),
        .out_ready (ord16),
        .out_data  (od16)
    );

    int checks   = 0;
    int failures = 0;

    sb_entry_t    sb1[$], sb16[$];
    string        nm1[$], nm16[$];
    logic [127:0] cap16[$];
    int           acc1 = 0, acc16 = 0;
    logic         ov1_prev = 1'b0, ov16_prev = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no event expected event within bound", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitors: compare on every output handshake and check rise latency against the accept cycle.
    sb_entry_t m1_e, m16_e;
    string     m1_n, m16_n;

    always @(negedge clk) begin
        if (ov1 && !ov1_prev && sb1.size() > 0 && sb1[0].lat != 0)
            check_int({nm1[0], "_latency"}, cyc - acc1, sb1[0].lat);
        ov1_prev = ov1;
        if (ov1 === 1'b1 && ord1 === 1'b1) begin
            if (sb1.size() == 0) begin
                fail("unexpected_out1");
            end else begin
                m1_e = sb1.pop_front();
                m1_n = nm1.pop_front();
                if (m1_e.chk) check(m1_n, od1, m1_e.exp);
            end
        end
    end

    always @(negedge clk) begin
        if (ov16 && !ov16_prev && sb16.size() > 0 && sb16[0].lat != 0)
            check_int({nm16[0], "_latency"}, cyc - acc16, sb16[0].lat);
        ov16_prev = ov16;
        if (ov16 === 1'b1 && ord16 === 1'b1) begin
            if (sb16.size() == 0) begin
                fail("unexpected_out16");
            end else begin
                m16_e = sb16.pop_front();
                m16_n = nm16.pop_front();
                if (m16_e.chk) check(m16_n, od16, m16_e.exp);
                else cap16.push_back(od16);
            end
        end
    end

    task automatic send(input bit big, input logic [127:0] d, input logic inv,
                        input logic [127:0] exp, input bit chk, input string name);
        sb_entry_t e;
        bit ok;
        ok    = 1'b0;
        e.chk = chk;
        e.exp = exp;
        e.lat = big ? 16 : 1;
        if (big) begin
            sb16.push_back(e); nm16.push_back(name);
            v16 = 1'b1; d16 = d; inv16 = inv;
        end else begin
            sb1.push_back(e); nm1.push_back(name);
            v1 = 1'b1; d1 = d; inv1 = inv;
        end
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = big ? (rdy16 === 1'b1) : (rdy1 === 1'b1);
        end
        if (!ok) fail({name, "_accept"});
        tick();
        // Scramble inputs after the accept; the DUT must ignore them.
        if (big) begin
            acc16 = cyc; v16 = 1'b0; d16 = ~d; inv16 = ~inv;
        end else begin
            acc1 = cyc; v1 = 1'b0; d1 = ~d; inv1 = ~inv;
        end
    endtask

    task automatic drain(input bit big);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = big ? (sb16.size() == 0) : (sb1.size() == 0);
        end
        if (!ok) begin
            fail(big ? "drain16" : "drain1");
            if (big) begin sb16.delete(); nm16.delete(); end
            else begin sb1.delete(); nm1.delete(); end
        end
        tick();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish before 600000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] x, y;
        int           p;
        bit           ok;

        v1 = 1'b0; d1 = '0; inv1 = 1'b0; ord1 = 1'b1;
        v16 = 1'b0; d16 = '0; inv16 = 1'b0; ord16 = 1'b1;
        rst = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("rst_in_ready16", rdy16, 1'b0);
        check_bit("rst_in_ready1", rdy1, 1'b0);
        check_bit("rst_out_valid16", ov16, 1'b0);
        check_bit("rst_out_valid1", ov1, 1'b0);
        check("rst_out_data16", od16, 128'h0);
        check("rst_out_data1", od1, 128'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_bit("post_rst_in_ready16", rdy16, 1'b1);
        check_bit("post_rst_in_ready1", rdy1, 1'b1);
        tick();

        // Single R steps, back to back
        send(1'b0, 128'h00000000000000000000000000000100, 1'b0,
             128'h94000000000000000000000000000001, 1'b1, "r1_fwd0");
        p = acc1;
        send(1'b0, 128'h94000000000000000000000000000001, 1'b0,
             128'ha5940000000000000000000000000000, 1'b1, "r1_chain1");
        check_int("r1_throughput", acc1 - p, 3);
        send(1'b0, 128'ha5940000000000000000000000000000, 1'b0,
             128'h64a59400000000000000000000000000, 1'b1, "r1_chain2");
        send(1'b0, 128'h64a59400000000000000000000000000, 1'b0,
             128'h0d64a594000000000000000000000000, 1'b1, "r1_chain3");
        send(1'b0, 128'h94000000000000000000000000000001, 1'b1,
             128'h00000000000000000000000000000100, 1'b1, "r1_inv");
        drain(1'b0);

        // Full L and L^-1
        send(1'b1, 128'h64a59400000000000000000000000000, 1'b0,
             128'hd456584dd0e3e84cc3166e4b7fa2890d, 1'b1, "l16_fwd");
        send(1'b1, 128'hd456584dd0e3e84cc3166e4b7fa2890d, 1'b0,
             128'h79d26221b87b584cd42fbc4ffea5de9a, 1'b1, "l16_fwd2");
        send(1'b1, 128'hd456584dd0e3e84cc3166e4b7fa2890d, 1'b1,
             128'h64a59400000000000000000000000000, 1'b1, "l16_inv");
        drain(1'b1);

        // Round trip L^-1(L(x)) = x
        for (int i = 0; i < 100; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            send(1'b1, x, 1'b0, 128'h0, 1'b0, "rt_fwd");
            drain(1'b1);
            if (cap16.size() == 0) begin
                fail($sformatf("rt_capture%0d", i));
            end else begin
                y = cap16.pop_front();
                send(1'b1, y, 1'b1, x, 1'b1, $sformatf("rt_inv%0d", i));
            end
        end
        drain(1'b1);

        // Backpressure in DONE
        ord16 = 1'b0;
        send(1'b1, 128'h64a59400000000000000000000000000, 1'b0,
             128'hd456584dd0e3e84cc3166e4b7fa2890d, 1'b1, "bp_out");
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = (ov16 === 1'b1);
        end
        if (!ok) fail("bp_wait_valid");
        v16 = 1'b1;
        d16 = 128'h0123456789abcdef0123456789abcdef;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_data", od16, 128'hd456584dd0e3e84cc3166e4b7fa2890d);
            check_bit("bp_hold_valid", ov16, 1'b1);
            check_bit("bp_hold_ready", rdy16, 1'b0);
        end
        tick();
        v16 = 1'b0;
        ord16 = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check_bit("bp_release_valid", ov16, 1'b0);
        check_bit("bp_release_idle", rdy16, 1'b1);
        check_int("bp_queue_empty", sb16.size(), 0);
        tick();

        // Reset during round 7
        v16 = 1'b1;
        d16 = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
        inv16 = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = (rdy16 === 1'b1);
        end
        if (!ok) fail("abort_accept");
        tick();
        v16 = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        @(negedge clk);
        check_bit("abort_rst_ready", rdy16, 1'b0);
        tick();
        @(negedge clk);
        check_bit("abort_out_valid", ov16, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_bit("abort_ready_after", rdy16, 1'b1);
        check_bit("abort_valid_after", ov16, 1'b0);
        tick();
        send(1'b1, 128'h64a59400000000000000000000000000, 1'b0,
             128'hd456584dd0e3e84cc3166e4b7fa2890d, 1'b1, "abort_next");
        drain(1'b1);

        check_int("final_sb1_empty", sb1.size(), 0);
        check_int("final_sb16_empty", sb16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
